// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_t;

    localparam logic [7:0] UART_CR = 8'h0D;
    localparam logic [7:0] UART_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side write port, status flags and serializer handshake of the feeder.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic [7:0]         wr_data;
    logic               wr_en;
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;
    logic               overflow;
    logic               timeout_err;
    logic               idle;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;

    modport master (
        input  wr_data, wr_en, tx_busy,
        output full, empty, level, overflow, timeout_err, idle, tx_data, tx_start
    );

    modport slave (
        output wr_data, wr_en, tx_busy,
        input  full, empty, level, overflow, timeout_err, idle, tx_data, tx_start
    );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a write-drop pulse.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              do_wr;
    logic              do_rd;

    // full is the pre-edge flag, so a write into a full FIFO is dropped even when a pop frees a slot
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (do_wr && !do_rd)
            level_nxt = level + LVL_W'(1);
        else if (do_rd && !do_wr)
            level_nxt = level - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + PTR_W'(1);
            level    <= level_nxt;
            full     <= (level_nxt == LVL_W'(DEPTH));
            empty    <= (level_nxt == '0);
            overflow <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one at a time into the UART serializer.
// Optional UART_TX_FEEDER_CRLF_EN: a queued LF is preceded on the wire by an inserted CR.
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_feeder_if.master bus
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    feeder_state_t    state;
    feeder_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       head;
    logic [7:0]       launch_data;
    logic             fifo_empty;
    logic             pop;
    logic             launch;
    logic             timeout_hit;
    logic             insert_cr;

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_data  (bus.wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (bus.full),
        .empty    (fifo_empty),
        .level    (bus.level),
        .overflow (bus.overflow)
    );

    assign bus.empty = fifo_empty;
    assign bus.idle  = fifo_empty && (state == IDLE);

`ifdef UART_TX_FEEDER_CRLF_EN
    logic cr_sent;

    assign insert_cr = (head == UART_LF) && !cr_sent;

    // Set by the CR launch (even if it later times out), cleared by the LF pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cr_sent <= 1'b0;
        else if (launch)
            cr_sent <= insert_cr;
    end
`else
    assign insert_cr = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        launch_data = head;
        case (state)
            // A busy serializer in IDLE belongs to someone else; never start over it
            IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                    if (insert_cr)
                        launch_data = UART_CR;
                    else
                        pop = 1'b1;
                end
            end
            LAUNCH: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cnt holds the number of cycles elapsed since the launch cycle began
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.tx_data     <= 8'h00;
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.tx_start    <= launch;
            bus.timeout_err <= timeout_hit;
            if (launch)
                bus.tx_data <= launch_data;
            if (state == LAUNCH)
                cnt <= CNT_W'(1);
            else if (state == WAIT_BUSY)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed vectors plus randomized traffic scored against a byte-stream model.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serializer: busy rises the cycle after a start and stays high ser_hold cycles
    logic ser_busy;
    logic foreign_busy = 1'b0;
    int   ser_hold = 20;
    bit   ser_dead = 1'b0;
    int   ser_cnt;

    assign bus.tx_busy = ser_busy | foreign_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_busy <= 1'b0;
            ser_cnt  <= 0;
        end else if (bus.tx_start && !ser_dead) begin
            ser_busy <= 1'b1;
            ser_cnt  <= ser_hold;
        end else if (ser_cnt > 1) begin
            ser_cnt <= ser_cnt - 1;
        end else begin
            ser_cnt  <= 0;
            ser_busy <= 1'b0;
        end
    end

    // Reference model: expected wire byte stream, occupancy count, timeout window
    typedef struct {
        logic [7:0] b;
        bit         pops;
    } tx_item_t;

    tx_item_t   stream[$];
    int         occ = 0;
    bit         wr_prev = 1'b0;
    logic [7:0] wd_prev = 8'h00;
    logic [7:0] last_data = 8'h00;
    bit         armed = 1'b0;
    int         since = 0;
    bit         saw_busy = 1'b0;
    int         n_starts = 0;
    int         ovf_cnt = 0;

    always @(negedge clk) begin
        bit       acc;
        bit       pop;
        tx_item_t it;
        if (rst) begin
            occ = 0;
            stream.delete();
            wr_prev   = 1'b0;
            last_data = 8'h00;
            armed     = 1'b0;
            since     = 0;
            saw_busy  = 1'b0;
        end else begin
            acc = wr_prev && (occ < DEPTH);
            chk("overflow", bus.overflow, wr_prev && (occ == DEPTH));
            if (bus.overflow) ovf_cnt++;
            if (acc) begin
`ifdef UART_TX_FEEDER_CRLF_EN
                if (wd_prev == UART_LF) stream.push_back('{UART_CR, 1'b0});
`endif
                stream.push_back('{wd_prev, 1'b1});
            end
            if (armed) since++;
            chk("timeout_err", bus.timeout_err, armed && since == BUSY_TIMEOUT && !saw_busy);
            if (bus.tx_busy) saw_busy = 1'b1;
            if (since >= BUSY_TIMEOUT) armed = 1'b0;
            pop = 1'b0;
            if (bus.tx_start) begin
                chk("start_while_busy", bus.tx_busy, 0);
                if (stream.size() == 0) begin
                    chk("start_without_pending_byte", stream.size(), 1);
                end else begin
                    it = stream.pop_front();
                    chk("tx_data", bus.tx_data, it.b);
                    pop = it.pops;
                end
                last_data = bus.tx_data;
                armed     = 1'b1;
                since     = 0;
                saw_busy  = 1'b0;
                n_starts++;
            end else begin
                chk("tx_data_hold", bus.tx_data, last_data);
            end
            occ = occ + int'(acc) - int'(pop);
            chk("level", bus.level, occ);
            chk("full", bus.full, occ == DEPTH);
            chk("empty", bus.empty, occ == 0);
            wr_prev = bus.wr_en;
            wd_prev = bus.wr_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_start(input string name, input int max, output int cyc);
        bit found = 1'b0;
        cyc = -1;
        for (int i = 1; i <= max && !found; i++) begin
            tick(1);
            if (bus.tx_start) begin
                cyc   = i;
                found = 1'b1;
            end
        end
        chk(name, found, 1);
    endtask

    task automatic wait_busy_fall(input int max);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            tick(1);
            if (bus.tx_busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        chk("busy_fall_in_time", done, 1);
    endtask

    task automatic wait_idle(input int max);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            tick(1);
            if (bus.idle && !bus.tx_busy) done = 1'b1;
        end
        chk("drain_in_time", done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_start"}, bus.tx_start, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
        chk({tag, "_full"}, bus.full, 0);
        chk({tag, "_empty"}, bus.empty, 1);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_timeout_err"}, bus.timeout_err, 0);
        chk({tag, "_idle"}, bus.idle, 1);
    endtask

    typedef struct {
        logic [7:0] wdata;
        int         nstarts;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        logic [7:0] rb;

        vecs[0] = '{8'h41, 1, 8'h41, 8'h00};
        vecs[1] = '{8'h00, 1, 8'h00, 8'h00};
        vecs[2] = '{8'hFF, 1, 8'hFF, 8'h00};
        vecs[3] = '{8'h0D, 1, 8'h0D, 8'h00};
`ifdef UART_TX_FEEDER_CRLF_EN
        vecs[4] = '{8'h0A, 2, 8'h0D, 8'h0A};
`else
        vecs[4] = '{8'h0A, 1, 8'h0A, 8'h00};
`endif

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(2);

        // Single-byte sends from idle
        foreach (vecs[k]) begin
            write_byte(vecs[k].wdata);
            wait_start("vec_start_seen", 4, cyc);
            chk("vec_latency", cyc + 1, 2);
            chk("vec_first_byte", bus.tx_data, vecs[k].d0);
            tick(1);
            chk("vec_start_one_cycle", bus.tx_start, 0);
            wait_busy_fall(40);
            if (vecs[k].nstarts == 2) begin
                wait_start("vec_second_start_seen", 4, cyc);
                chk("vec_second_gap", cyc, 2);
                chk("vec_second_byte", bus.tx_data, vecs[k].d1);
                wait_busy_fall(40);
            end
            tick(1);
            chk("vec_idle_after_busy", bus.idle, 1);
        end

        // Fill to full behind a foreign-busy serializer, then overflow during a pop
        foreign_busy = 1'b1;
        tick(1);
        base = ovf_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h10 + 8'(i);
            tick(1);
        end
        bus.wr_en = 1'b0;
        chk("fill_level", bus.level, DEPTH);
        chk("fill_full", bus.full, 1);
        chk("fill_no_overflow", ovf_cnt - base, 0);
        bus.wr_en    = 1'b1;
        bus.wr_data  = 8'h99;
        foreign_busy = 1'b0;
        tick(1);
        bus.wr_en = 1'b0;
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_pop_same_edge", bus.tx_start, 1);
        chk("ovf_first_byte", bus.tx_data, 8'h10);
        chk("ovf_level_after_pop", bus.level, DEPTH - 1);
        tick(1);
        chk("ovf_one_cycle", bus.overflow, 0);
        for (int i = 1; i < DEPTH; i++) begin
            wait_busy_fall(40);
            wait_start("b2b_start_seen", 4, cyc);
            chk("b2b_gap", cyc, 2);
            chk("b2b_order", bus.tx_data, 8'h10 + 8'(i));
        end
        wait_busy_fall(40);
        base = n_starts;
        tick(30);
        chk("dropped_byte_not_sent", n_starts - base, 0);
        chk("idle_after_burst", bus.idle, 1);

        // Serializer never answers: both bytes abandoned after the timeout
        ser_dead    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        tick(1);
        bus.wr_data = 8'h66;
        tick(1);
        bus.wr_en = 1'b0;
        chk("to_first_start", bus.tx_start, 1);
        chk("to_first_byte", bus.tx_data, 8'h55);
        for (int pass = 0; pass < 2; pass++) begin
            cyc = -1;
            for (int i = 1; i <= 20 && cyc < 0; i++) begin
                tick(1);
                if (bus.timeout_err) cyc = i;
            end
            chk("to_delay", cyc, BUSY_TIMEOUT);
            tick(1);
            chk("to_one_cycle", bus.timeout_err, 0);
            if (pass == 0) begin
                chk("to_relaunch", bus.tx_start, 1);
                chk("to_relaunch_byte", bus.tx_data, 8'h66);
            end else begin
                chk("to_idle_after", bus.idle, 1);
            end
        end
        ser_dead = 1'b0;
        tick(2);

        // Reset in WAIT_DONE with bytes queued
        ser_hold = 20;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = 8'hA1 + 8'(i);
            tick(1);
        end
        bus.wr_en = 1'b0;
        tick(4);
        chk("pre_reset_busy", bus.tx_busy, 1);
        chk("pre_reset_level", bus.level, 3);
        rst = 1'b1;
        #1;
        check_reset_values("midbyte_reset");
        tick(2);
        rst  = 1'b0;
        base = n_starts;
        tick(40);
        chk("no_start_after_reset", n_starts - base, 0);
        chk("level_after_reset", bus.level, 0);
        write_byte(8'h77);
        wait_start("post_reset_start_seen", 4, cyc);
        chk("post_reset_latency", cyc + 1, 2);
        chk("post_reset_byte", bus.tx_data, 8'h77);
        wait_busy_fall(40);
        tick(1);

        // Foreign launch: serializer busy while idle blocks the next start
        foreign_busy = 1'b1;
        write_byte(8'h33);
        base = n_starts;
        tick(10);
        chk("foreign_hold", n_starts - base, 0);
        chk("foreign_level", bus.level, 1);
        foreign_busy = 1'b0;
        wait_start("foreign_release_seen", 4, cyc);
        chk("foreign_release_latency", cyc, 1);
        chk("foreign_byte", bus.tx_data, 8'h33);
        wait_busy_fall(40);
        tick(1);

        // Randomized traffic against the stream model
        for (int i = 0; i < 800; i++) begin
            bus.wr_en = ($urandom_range(0, 9) < 4);
            rb = 8'($urandom);
            bus.wr_data = ($urandom_range(0, 7) == 0) ? UART_LF : rb;
            ser_hold = $urandom_range(1, 6);
            ser_dead = ($urandom_range(0, 29) == 0);
            tick(1);
        end
        bus.wr_en = 1'b0;
        ser_dead  = 1'b0;
        wait_idle(3000);
        chk("stream_drained", stream.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
